// File: rtl/cb_cfg_pkg.sv
// cb_cfg_pkg: shared types and constants for the
// connection-box configuration sequencer.
package cb_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_BCAST,
    ST_SETTLE
  } state_t;

  localparam logic [7:0] CB_REG_SEL = 8'd0;

  localparam int REG_MSB  = 31;
  localparam int REG_LSB  = 24;
  localparam int TILE_MSB = 15;
  localparam int TILE_LSB = 0;

endpackage

// File: rtl/cb_cfg_sequencer_if.sv
// cb_cfg_sequencer_if: host command bus, valid/ready.
// master = host, slave = sequencer.
interface cb_cfg_sequencer_if;

  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] data;
  logic        bcast;

  modport master (
    output valid, addr, data, bcast,
    input  ready
  );

  modport slave (
    input  valid, addr, data, bcast,
    output ready
  );

endinterface

// File: rtl/cb_cfg_sequencer.sv
// cb_cfg_sequencer: writes one tile or broadcasts to all
// tiles, settle gap, saturating dropped-command counter.
module cb_cfg_sequencer
  import cb_cfg_pkg::*;
#(
  parameter int NUM_TILES = 16,
  parameter int GAP       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  cb_cfg_sequencer_if.slave    cmd,
  output logic [31:0]          config_addr,
  output logic [31:0]          config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           err_count
);

  localparam int CW =
    (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int GW =
    (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] IDX_LAST =
    CW'(NUM_TILES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [15:0] NT16 = 16'(NUM_TILES);

  state_t state_q, state_d;

  logic [CW-1:0]        idx_q, idx_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [NUM_TILES-1:0] en_q, en_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7:0]           err_q, err_d;

  logic        accept;
  logic        tile_ok;
  logic        last_wr;
  logic [15:0] tile;
  logic        unused_rsvd;

  assign tile    = cmd.addr[TILE_MSB:TILE_LSB];
  assign accept  = cmd.valid & ready_q;
  assign tile_ok = tile < NT16;
  assign last_wr = (state_q == ST_WRITE) ||
                   ((state_q == ST_BCAST) &&
                    (idx_q == IDX_LAST));

  assign unused_rsvd =
    ^cmd.addr[REG_LSB-1:TILE_MSB+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && cmd.bcast) begin
          state_d = ST_BCAST;
          idx_d   = '0;
        end else if (accept && tile_ok) begin
          state_d = ST_WRITE;
          idx_d   = tile[CW-1:0];
        end
      end
      ST_WRITE, ST_BCAST: begin
        if (last_wr) begin
          state_d = (GAP > 0) ? ST_SETTLE : ST_IDLE;
          gap_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the
  // strobe is visible in the cycle right after accept.
  always_comb begin
    en_d = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      en_d[i] = ((state_d == ST_WRITE) ||
                 (state_d == ST_BCAST)) &&
                (idx_d == CW'(i));
    end
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = last_wr;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept && (cmd.bcast || tile_ok)) begin
      addr_d = {cmd.addr[REG_MSB:REG_LSB], 24'd0};
      data_d = cmd.data;
    end
    err_d = err_q;
    if (accept && !cmd.bcast && !tile_ok &&
        (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  assign cmd.ready   = ready_q;
  assign config_addr = addr_q;
  assign config_data = data_q;
  assign config_en   = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_cb_cfg_sequencer.sv
// tb_cb_cfg_sequencer: directed + random stimulus against
// a transaction-level schedule model of the sequencer.
module tb_cb_cfg_sequencer;
  import cb_cfg_pkg::*;

  localparam int NT  = 16;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cb_cfg_sequencer_if cmd ();

  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic [NT-1:0] config_en;
  logic busy;
  logic done;
  logic [7:0] err_count;

  cb_cfg_sequencer #(
    .NUM_TILES(NT),
    .GAP(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd(cmd),
    .config_addr(config_addr),
    .config_data(config_data),
    .config_en(config_en),
    .busy(busy),
    .done(done),
    .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: each accepted command schedules its strobes
  // into a queue and fixes the cycles of done/ready.
  int c;
  int ready_at;
  int done_at;
  bit m_ready;
  bit m_acc;
  bit e_done;
  bit e_busy;
  logic [NT-1:0] e_en;
  logic [31:0] e_addr;
  logic [31:0] e_data;
  int e_err;
  logic [NT-1:0] plan[$];
  bit run = 1'b0;
  int hits[NT];

  task automatic model_reset();
    c = -1;
    ready_at = 0;
    done_at = -100;
    m_ready = 1'b0;
    m_acc = 1'b0;
    plan.delete();
    e_en = '0;
    e_done = 1'b0;
    e_busy = 1'b0;
    e_addr = '0;
    e_data = '0;
    e_err = 0;
  endtask

  task automatic model_edge();
    logic [NT-1:0] one;
    int t;
    one = 1;
    c++;
    m_acc = cmd.valid && m_ready;
    t = int'(cmd.addr[15:0]);
    if (m_acc) begin
      if (cmd.bcast || t < NT) begin
        e_addr = {cmd.addr[31:24], 24'd0};
        e_data = cmd.data;
      end
      if (cmd.bcast) begin
        for (int k = 0; k < NT; k++)
          plan.push_back(one << k);
        done_at = c + NT;
        ready_at = done_at + GAP;
      end else if (t < NT) begin
        plan.push_back(one << t);
        done_at = c + 1;
        ready_at = done_at + GAP;
      end else if (e_err < 255) begin
        e_err++;
      end
    end
    e_en = (plan.size() > 0) ? plan.pop_front() : '0;
    e_done = (c == done_at);
    m_ready = (c >= ready_at);
    e_busy = !m_ready;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NT; i++)
      if (config_en[i] === 1'b1) hits[i]++;
    if (reset) begin
      chk("rst_en", 32'(config_en), 0);
      chk("rst_addr", config_addr, 0);
      chk("rst_data", config_data, 0);
      chk("rst_ready", 32'(cmd.ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err_count), 0);
    end else if (run) begin
      chk("en", 32'(config_en), 32'(e_en));
      chk("addr", config_addr, e_addr);
      chk("data", config_data, e_data);
      chk("ready", 32'(cmd.ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err_count), 32'(e_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (!reset) model_edge();
    #2;
  endtask

  task automatic drive(input bit v, input bit b,
                       input logic [31:0] a,
                       input logic [31:0] d);
    cmd.valid = v;
    cmd.bcast = b;
    cmd.addr = a;
    cmd.data = d;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!m_ready && n < budget) begin
      cyc();
      n++;
    end
    if (!m_ready) chk("wait_timeout", 0, 1);
  endtask

  task automatic send(input bit b,
                      input logic [31:0] a,
                      input logic [31:0] d);
    wait_ready(100);
    drive(1'b1, b, a, d);
    cyc();
    cmd.valid = 1'b0;
  endtask

  task automatic clear_hits();
    for (int i = 0; i < NT; i++) hits[i] = 0;
  endtask

  logic [NT-1:0] one_h;

  initial begin
    one_h = 1;
    model_reset();
    clear_hits();
    drive(1'b1, 1'b0, 32'h3, 32'h5);
    #1 reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cmd.valid = 1'b0;
    run = 1'b1;
    cyc();
    chk("ready_after_release", 32'(cmd.ready), 1);

    send(1'b0, 32'h0000_0003, 32'd5);
    chk("single_en", 32'(config_en), 32'h8);
    chk("single_addr", config_addr, 0);
    chk("single_data", config_data, 5);
    chk("single_ready0", 32'(cmd.ready), 0);
    cyc();
    chk("single_done", 32'(done), 1);
    chk("single_en_off", 32'(config_en), 0);
    chk("single_ready1", 32'(cmd.ready), 0);
    cyc();
    chk("single_ready_back", 32'(cmd.ready), 1);

    send(1'b0, 32'h0000_0014, 32'hAA);
    chk("oor_err", 32'(err_count), 1);
    chk("oor_ready", 32'(cmd.ready), 1);
    chk("oor_en", 32'(config_en), 0);
    cmd.valid = 1'b1;
    repeat (299) cyc();
    cmd.valid = 1'b0;
    chk("oor_sat", 32'(err_count), 255);
    chk("oor_data_kept", config_data, 5);

    send(1'b1, {CB_REG_SEL, 24'h00_0000}, 32'd2);
    for (int k = 0; k < NT; k++) begin
      chk("bc_en", 32'(config_en), 32'(one_h << k));
      chk("bc_busy", 32'(busy), 1);
      chk("bc_ready", 32'(cmd.ready), 0);
      cyc();
    end
    chk("bc_done", 32'(done), 1);
    chk("bc_en_off", 32'(config_en), 0);

    wait_ready(100);
    clear_hits();
    send(1'b1, 32'h0700_0000, 32'd9);
    repeat (5) cyc();
    chk("rb_tile5", 32'(config_en), 32'h20);
    @(negedge clk);
    #1 reset = 1'b1;
    model_reset();
    #1 chk("rb_en_clr", 32'(config_en), 0);
    chk("rb_busy_clr", 32'(busy), 0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (30) cyc();
    for (int i = 0; i < NT; i++)
      chk("rb_hits", 32'(hits[i]), (i < 6) ? 1 : 0);

    clear_hits();
    send(1'b0, 32'h0000_0007, 32'h77);
    drive(1'b1, 1'b0, 32'h0000_0009, 32'h99);
    begin
      int n;
      n = 0;
      do begin
        cyc();
        n++;
      end while (!m_acc && n < 20);
      if (!m_acc) chk("bp_timeout", 0, 1);
    end
    cmd.valid = 1'b0;
    chk("bp_en", 32'(config_en), 32'h200);
    repeat (10) cyc();
    chk("bp_hits9", 32'(hits[9]), 1);
    chk("bp_hits7", 32'(hits[7]), 1);

    for (int n = 0; n < 800; n++) begin
      if (!cmd.valid || m_acc) begin
        logic [15:0] t;
        t = ($urandom_range(0, 9) == 0) ?
            16'($urandom) : 16'($urandom_range(0, 31));
        drive($urandom_range(0, 3) != 0,
              $urandom_range(0, 7) == 0,
              {8'($urandom), 8'($urandom), t},
              $urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        cmd.valid = 1'b0;
      end
      cyc();
    end
    cmd.valid = 1'b0;
    repeat (25) cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
